// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache refill-port arbiter.
// State encoding, one-hot grant codes and default line geometry.
// Imported by cache_mem_arbiter and rr_arbiter2.
package cache_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // One-hot grant encoding {m1,m0}
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Default line geometry: 4 words per burst, 2-bit word counter
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_CNT_WIDTH  = 2;

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational 2-way round-robin pick, one-hot grant out.
// Zero latency; a lone requester always wins, a tie goes to the one not granted last.
// Kept generic so a later victim-writeback port can reuse it.
module rr_arbiter2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req_i,    // {req1, req0}
    input  logic [1:0] last_i,   // one-hot grant of the previous burst
    output logic [1:0] gnt_o     // one-hot pick, GNT_NONE when nobody requests
);

    // Tie-break against the previous winner; otherwise the request vector is already one-hot or empty
    always_comb begin
        gnt_o = GNT_NONE;
        if (req_i == 2'b11) begin
            gnt_o = (last_i == GNT_M0) ? GNT_M1 : GNT_M0;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one word-wide memory refill port between the I-cache (m0) and D-cache (m1).
// Grant registered one cycle after request; held for LINE_WORDS acks, then one idle bubble before rearbitration.
// Optional watchdog under `CACHE_ARB_TIMEOUT_EN adds err_o and aborts a burst after TIMEOUT ack-less cycles.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADR_WIDTH  = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
`ifdef CACHE_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req_i,
    input  logic [ADR_WIDTH-1:0]  m0_adr_i,
    output logic                  m0_ack_o,
    output logic [WORD_WIDTH-1:0] m0_dat_o,

    input  logic                  m1_req_i,
    input  logic [ADR_WIDTH-1:0]  m1_adr_i,
    output logic                  m1_ack_o,
    output logic [WORD_WIDTH-1:0] m1_dat_o,

    output logic                  mem_req_o,
    output logic [ADR_WIDTH-1:0]  mem_adr_o,
    input  logic                  mem_ack_i,
    input  logic [WORD_WIDTH-1:0] mem_dat_i,

    output logic [1:0]            gnt_o,
    output logic                  busy_o
`ifdef CACHE_ARB_TIMEOUT_EN
    ,
    output logic                  err_o
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LINE_WORDS - 1);

    state_t               state_q;
    logic [1:0]           gnt_q;
    logic [1:0]           last_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [1:0]           pick;
    logic                 gnt_req;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q;
    assign err_o = err_q;
`endif

    rr_arbiter2 u_rr (
        .req_i  ({m1_req_i, m0_req_i}),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Request line of whoever currently owns the port; low means the owner gave up the burst
    assign gnt_req = |(gnt_q & {m1_req_i, m0_req_i});

    // Steer the shared port by the registered grant; nothing is driven while idle
    always_comb begin
        mem_req_o = 1'b0;
        mem_adr_o = '0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        if (gnt_q == GNT_M0) begin
            mem_req_o = m0_req_i;
            mem_adr_o = m0_adr_i;
            m0_ack_o  = mem_ack_i;
        end else if (gnt_q == GNT_M1) begin
            mem_req_o = m1_req_i;
            mem_adr_o = m1_adr_i;
            m1_ack_o  = mem_ack_i;
        end
    end

    // Read data fans out to both caches unqualified; each cache gates it with its own ack
    assign m0_dat_o = mem_dat_i;
    assign m1_dat_o = mem_dat_i;
    assign gnt_o    = gnt_q;
    assign busy_o   = (state_q == BURST);

    // IDLE/BURST control: grant capture, word counting, end-of-line, abort and watchdog exits
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_NONE;
            last_q  <= GNT_M1;
            cnt_q   <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
`ifdef CACHE_ARB_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick != GNT_NONE) begin
                        gnt_q   <= pick;
                        cnt_q   <= '0;
                        state_q <= BURST;
`ifdef CACHE_ARB_TIMEOUT_EN
                        wd_q    <= '0;
`endif
                    end
                end
                BURST: begin
                    if (mem_ack_i) begin
                        cnt_q <= cnt_q + 1'b1;
`ifdef CACHE_ARB_TIMEOUT_EN
                        wd_q  <= '0;
`endif
                    end
                    if (mem_ack_i && (cnt_q == CNT_LAST)) begin
                        // Last word of the line delivered
                        last_q  <= gnt_q;
                        gnt_q   <= GNT_NONE;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (!gnt_req) begin
                        // Owner dropped its request; any ack this cycle was still forwarded
                        last_q  <= gnt_q;
                        gnt_q   <= GNT_NONE;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
`ifdef CACHE_ARB_TIMEOUT_EN
                    else if (!mem_ack_i) begin
                        if (wd_q == WD_LAST) begin
                            // Memory went silent too long: flag it and free the port
                            err_q   <= 1'b1;
                            last_q  <= gnt_q;
                            gnt_q   <= GNT_NONE;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= GNT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: per-cycle vector table plus a data scoreboard.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Define CACHE_ARB_TIMEOUT_EN to include the watchdog sequence (TIMEOUT=8).
module tb_cache_mem_arbiter;

    localparam logic [31:0] M0_ADR = 32'h0000_1040;
    localparam logic [31:0] M1_ADR = 32'h0000_2080;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_adr_i, m1_adr_i;
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        mem_req_o;
    logic [31:0] mem_adr_o;
    logic        mem_ack_i;
    logic [31:0] mem_dat_i;
    logic [1:0]  gnt_o;
    logic        busy_o;
`ifdef CACHE_ARB_TIMEOUT_EN
    logic        err_o;
`endif

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .ADR_WIDTH  (32),
        .WORD_WIDTH (32),
        .LINE_WORDS (4),
        .CNT_WIDTH  (2)
`ifdef CACHE_ARB_TIMEOUT_EN
        ,
        .TIMEOUT    (8)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req_i  (m0_req_i),
        .m0_adr_i  (m0_adr_i),
        .m0_ack_o  (m0_ack_o),
        .m0_dat_o  (m0_dat_o),
        .m1_req_i  (m1_req_i),
        .m1_adr_i  (m1_adr_i),
        .m1_ack_o  (m1_ack_o),
        .m1_dat_o  (m1_dat_o),
        .mem_req_o (mem_req_o),
        .mem_adr_o (mem_adr_o),
        .mem_ack_i (mem_ack_i),
        .mem_dat_i (mem_dat_i),
        .gnt_o     (gnt_o),
        .busy_o    (busy_o)
`ifdef CACHE_ARB_TIMEOUT_EN
        ,
        .err_o     (err_o)
`endif
    );

    // One clock cycle: inputs applied and outputs expected within that cycle
    typedef struct {
        logic        rst;
        logic        r0;
        logic        r1;
        logic [31:0] m1adr;
        logic        ack;
        logic [31:0] dat;
        logic [1:0]  egnt;
        logic        emreq;
        logic [1:0]  eack;
        logic        eerr;
    } vec_t;

    vec_t        tbl[$];
    logic [33:0] sb_q[$];   // {ack port one-hot, data}
    int          n_chk = 0;
    int          n_err = 0;

    function automatic void add(input logic rst_v, input logic r0, input logic r1,
                                input logic [31:0] m1adr, input logic ack, input logic [31:0] dat,
                                input logic [1:0] egnt, input logic emreq, input logic [1:0] eack,
                                input logic eerr);
        vec_t v;
        v.rst = rst_v; v.r0 = r0; v.r1 = r1; v.m1adr = m1adr; v.ack = ack; v.dat = dat;
        v.egnt = egnt; v.emreq = emreq; v.eack = eack; v.eerr = eerr;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int idx, input vec_t v);
        logic [31:0] eadr;
        logic [33:0] e;
        @(posedge clk);
        #1;
        rst       = v.rst;
        m0_req_i  = v.r0;
        m1_req_i  = v.r1;
        m0_adr_i  = M0_ADR;
        m1_adr_i  = v.m1adr;
        mem_ack_i = v.ack;
        mem_dat_i = v.dat;
        if (v.ack && v.eack != 2'b00) sb_q.push_back({v.eack, v.dat});
        @(negedge clk);
        eadr = (v.egnt == 2'b01) ? M0_ADR : (v.egnt == 2'b10) ? v.m1adr : 32'h0;
        chk($sformatf("v%0d gnt", idx),   64'(gnt_o),     64'(v.egnt));
        chk($sformatf("v%0d busy", idx),  64'(busy_o),    64'(v.egnt != 2'b00));
        chk($sformatf("v%0d mreq", idx),  64'(mem_req_o), 64'(v.emreq));
        chk($sformatf("v%0d acks", idx),  64'({m1_ack_o, m0_ack_o}), 64'(v.eack));
        chk($sformatf("v%0d madr", idx),  64'(mem_adr_o), 64'(eadr));
        chk($sformatf("v%0d dat", idx),   64'({m1_dat_o, m0_dat_o}), {v.dat, v.dat});
`ifdef CACHE_ARB_TIMEOUT_EN
        chk($sformatf("v%0d err", idx),   64'(err_o),     64'(v.eerr));
`endif
        if (m0_ack_o || m1_ack_o) begin
            if (sb_q.size() == 0) begin
                chk($sformatf("v%0d sb_unexpected_ack", idx), 64'({m1_ack_o, m0_ack_o}), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("v%0d sb_word", idx),
                    64'({m1_ack_o, m0_ack_o, (m0_ack_o ? m0_dat_o : m1_dat_o)}), 64'(e));
            end
        end
    endtask

    initial begin
        rst = 1'b1; m0_req_i = 0; m1_req_i = 0; m0_adr_i = M0_ADR; m1_adr_i = M1_ADR;
        mem_ack_i = 0; mem_dat_i = '0;

        // Reset state, hand-checked
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset gnt",  64'(gnt_o), 64'(0));
        chk("reset busy", 64'(busy_o), 64'(0));
        chk("reset mreq", 64'(mem_req_o), 64'(0));
        chk("reset madr", 64'(mem_adr_o), 64'(0));
        chk("reset acks", 64'({m1_ack_o, m0_ack_o}), 64'(0));

        // Single m0 burst, 4 back-to-back acks
        add(0,1,0,M1_ADR,0,0,          2'b00,0,2'b00,0);
        for (int i = 0; i < 4; i++) add(0,1,0,M1_ADR,1,32'hA0 + i, 2'b01,1,2'b01,0);
        add(0,0,0,M1_ADR,0,0,          2'b00,0,2'b00,0);

        // Reset, then both request for three bursts: m0, m1, m0 with bubbles
        add(1,0,0,M1_ADR,0,0,          2'b00,0,2'b00,0);
        add(0,1,1,M1_ADR,0,0,          2'b00,0,2'b00,0);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++)
                add(0,1,1,M1_ADR,1,32'hB0 + 16*b + i, (b == 1) ? 2'b10 : 2'b01,1,
                    (b == 1) ? 2'b10 : 2'b01,0);
            if (b < 2) add(0,1,1,M1_ADR,0,0, 2'b00,0,2'b00,0);
        end
        add(0,0,0,M1_ADR,0,0,          2'b00,0,2'b00,0);

        // m1 burst with memory stalls: acks on burst cycles 1,5,6,9, address moving
        add(0,0,1,32'h3000,0,0,        2'b00,0,2'b00,0);
        begin
            int k;
            k = 0;
            for (int c = 1; c <= 9; c++) begin
                logic a;
                a = (c == 1) || (c == 5) || (c == 6) || (c == 9);
                add(0,0,1,32'h3000 + 4*c, a, a ? 32'hE0 + k : 32'h0, 2'b10,1, a ? 2'b10 : 2'b00,0);
                if (a) k++;
            end
        end
        add(0,0,0,M1_ADR,0,0,          2'b00,0,2'b00,0);

        // m1 aborts after 2 acks while m0 waits; m0 then wins the tie
        add(0,0,1,M1_ADR,0,0,          2'b00,0,2'b00,0);
        add(0,1,1,M1_ADR,1,32'hF0,     2'b10,1,2'b10,0);
        add(0,1,1,M1_ADR,1,32'hF1,     2'b10,1,2'b10,0);
        add(0,1,0,M1_ADR,0,0,          2'b10,0,2'b00,0);
        add(0,1,1,M1_ADR,0,0,          2'b00,0,2'b00,0);
        // m0 drops its request on the same cycle as an ack: ack still delivered
        add(0,1,1,M1_ADR,1,32'hC0,     2'b01,1,2'b01,0);
        add(0,0,1,M1_ADR,1,32'hC1,     2'b01,0,2'b01,0);
        add(0,0,1,M1_ADR,0,0,          2'b00,0,2'b00,0);
        // m1 burst interrupted by reset after one ack
        add(0,0,1,M1_ADR,1,32'hD0,     2'b10,1,2'b10,0);
        add(1,0,1,M1_ADR,0,0,          2'b10,1,2'b00,0);
        add(0,1,0,M1_ADR,0,0,          2'b00,0,2'b00,0);
        for (int i = 0; i < 4; i++) add(0,1,0,M1_ADR,1,32'h90 + i, 2'b01,1,2'b01,0);
        add(0,0,0,M1_ADR,0,0,          2'b00,0,2'b00,0);

`ifdef CACHE_ARB_TIMEOUT_EN
        // Watchdog: 8 ack-less burst cycles, error pulse, then the other requester wins
        add(0,1,0,M1_ADR,0,0,          2'b00,0,2'b00,0);
        for (int i = 0; i < 8; i++) add(0,1,0,M1_ADR,0,0, 2'b01,1,2'b00,0);
        add(0,1,1,M1_ADR,0,0,          2'b00,0,2'b00,1);
        add(0,1,1,M1_ADR,0,0,          2'b10,1,2'b00,0);
        add(1,0,0,M1_ADR,0,0,          2'b10,0,2'b00,0);
        add(0,0,0,M1_ADR,0,0,          2'b00,0,2'b00,0);
`endif

        foreach (tbl[i]) step(i, tbl[i]);

        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
